// File: rtl/hazard_pkg.sv
// Shared types for the ID/EX forwarding and hazard controller.
package hazard_pkg;

  localparam int REG_W_DEF = 5;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'b00,
    CAUSE_LOAD_USE  = 2'b01,
    CAUSE_MC_DEP    = 2'b10,
    CAUSE_MC_STRUCT = 2'b11
  } stall_cause_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/fwd_select.sv
// Bypass source select for one operand: youngest matching writer wins, x0 never forwarded.
module fwd_select #(
  parameter int REG_W   = 5,
  parameter int NUM_STG = 2,
  parameter int SEL_W   = $clog2(NUM_STG + 1)
) (
  input  logic [REG_W-1:0]         rs,
  input  logic [NUM_STG*REG_W-1:0] stg_rd,
  input  logic [NUM_STG-1:0]       stg_we,
  output logic [SEL_W-1:0]         sel
);

  // Walk oldest to youngest so the lowest matching index overwrites the rest.
  always_comb begin
    sel = '0;
    for (int k = NUM_STG - 1; k >= 0; k--) begin
      if (stg_we[k] && (stg_rd[k*REG_W +: REG_W] == rs) && (rs != '0)) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand bypass selection, load-use detection and single-outstanding
// multicycle scoreboard with timeout between the ID and EX stages.
module fwd_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W      = REG_W_DEF,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STG    = 2,
  parameter int MC_TIMEOUT = 64,
  parameter int SEL_W      = $clog2(NUM_STG + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*REG_W-1:0] rs_ex,
  input  logic [NUM_STG*REG_W-1:0] stg_rd,
  input  logic [NUM_STG-1:0]       stg_we,
  input  logic [NUM_SRC*REG_W-1:0] rs_id,
  input  logic                     id_is_mc,
  input  logic [REG_W-1:0]         ex_rd,
  input  logic                     ex_we,
  input  logic                     ex_is_load,
  input  logic                     ex_mc_start,
  input  logic                     mc_done,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     fwd_any,
  output logic                     stall_id,
  output logic [1:0]               stall_cause,
  output logic                     mc_busy,
  output logic                     mc_err,
  output mc_state_e                mc_state
);

  localparam int CNT_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

  mc_state_e        state;
  logic [REG_W-1:0] mc_rd;
  logic [CNT_W-1:0] cnt;
  logic             err;

  logic [NUM_SRC-1:0] sel_nz;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_select #(
      .REG_W  (REG_W),
      .NUM_STG(NUM_STG),
      .SEL_W  (SEL_W)
    ) u_fwd_select (
      .rs    (rs_ex[s*REG_W +: REG_W]),
      .stg_rd(stg_rd),
      .stg_we(stg_we),
      .sel   (fwd_sel[s*SEL_W +: SEL_W])
    );
    assign sel_nz[s] = |fwd_sel[s*SEL_W +: SEL_W];
  end

  assign fwd_any = |sel_nz;

  // Stall is decoded from the registered state, so the mc_done cycle still
  // stalls and release happens once the result is readable from the regfile.
  logic         load_hit;
  logic         dep_hit;
  stall_cause_e cause;

  always_comb begin
    load_hit = 1'b0;
    dep_hit  = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (rs_id[s*REG_W +: REG_W] == ex_rd) load_hit = 1'b1;
      if ((rs_id[s*REG_W +: REG_W] != '0) && (rs_id[s*REG_W +: REG_W] == mc_rd)) dep_hit = 1'b1;
    end
    load_hit = load_hit && ex_we && ex_is_load && (ex_rd != '0);

    cause = CAUSE_NONE;
    if (load_hit)                        cause = CAUSE_LOAD_USE;
    else if ((state == BUSY) && dep_hit)  cause = CAUSE_MC_DEP;
    else if ((state == BUSY) && id_is_mc) cause = CAUSE_MC_STRUCT;
  end

  assign stall_cause = cause;
  assign stall_id    = (cause != CAUSE_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mc_rd <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_mc_start && ex_we && (ex_rd != '0)) begin
            state <= BUSY;
            mc_rd <= ex_rd;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
          // A second start cannot be tracked; it is dropped and flagged.
          if (ex_mc_start) err <= 1'b1;
          if (mc_done) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            err   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mc_busy  = (state == BUSY);
  assign mc_err   = err;
  assign mc_state = state;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding, load-use, multicycle scoreboard, timeout, reset.
module tb_fwd_hazard_ctrl;
  import hazard_pkg::*;

  localparam int REG_W      = 5;
  localparam int NUM_SRC    = 2;
  localparam int NUM_STG    = 2;
  localparam int MC_TIMEOUT = 64;
  localparam int SEL_W      = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_SRC*REG_W-1:0] rs_ex;
  logic [NUM_STG*REG_W-1:0] stg_rd;
  logic [NUM_STG-1:0]       stg_we;
  logic [NUM_SRC*REG_W-1:0] rs_id;
  logic                     id_is_mc;
  logic [REG_W-1:0]         ex_rd;
  logic                     ex_we;
  logic                     ex_is_load;
  logic                     ex_mc_start;
  logic                     mc_done;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     fwd_any;
  logic                     stall_id;
  logic [1:0]               stall_cause;
  logic                     mc_busy;
  logic                     mc_err;
  mc_state_e                mc_state;

  int n_chk  = 0;
  int n_pass = 0;

  fwd_hazard_ctrl #(
    .REG_W     (REG_W),
    .NUM_SRC   (NUM_SRC),
    .NUM_STG   (NUM_STG),
    .MC_TIMEOUT(MC_TIMEOUT),
    .SEL_W     (SEL_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_ex      (rs_ex),
    .stg_rd     (stg_rd),
    .stg_we     (stg_we),
    .rs_id      (rs_id),
    .id_is_mc   (id_is_mc),
    .ex_rd      (ex_rd),
    .ex_we      (ex_we),
    .ex_is_load (ex_is_load),
    .ex_mc_start(ex_mc_start),
    .mc_done    (mc_done),
    .fwd_sel    (fwd_sel),
    .fwd_any    (fwd_any),
    .stall_id   (stall_id),
    .stall_cause(stall_cause),
    .mc_busy    (mc_busy),
    .mc_err     (mc_err),
    .mc_state   (mc_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_ex = '0; stg_rd = '0; stg_we = '0; rs_id = '0; id_is_mc = 1'b0;
    ex_rd = '0; ex_we = 1'b0; ex_is_load = 1'b0; ex_mc_start = 1'b0; mc_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic start_mc(input logic [REG_W-1:0] rd);
    ex_mc_start = 1'b1; ex_we = 1'b1; ex_rd = rd; ex_is_load = 1'b0;
    tick();
    ex_mc_start = 1'b0; ex_we = 1'b0; ex_rd = '0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #3;
    check("rst_stall",  32'(stall_id), 32'd0);
    check("rst_cause",  32'(stall_cause), 32'd0);
    check("rst_fwd",    32'(fwd_sel), 32'd0);
    check("rst_busy",   32'(mc_busy), 32'd0);
    check("rst_err",    32'(mc_err), 32'd0);
    check("rst_state",  32'(mc_state), 32'(IDLE));
    do_reset();

    // forwarding
    rs_ex = {5'd0, 5'd5}; stg_rd = {5'd5, 5'd5}; stg_we = 2'b11; #1;
    check("fwd_young", 32'(fwd_sel), 32'h1);
    check("fwd_any1",  32'(fwd_any), 32'd1);
    stg_we = 2'b10; #1;
    check("fwd_old",   32'(fwd_sel), 32'h2);
    rs_ex = {5'd3, 5'd5}; stg_rd = {5'd5, 5'd3}; stg_we = 2'b11; #1;
    check("fwd_both",  32'(fwd_sel), 32'h6);
    stg_we = 2'b00; #1;
    check("fwd_nowe",  32'(fwd_sel), 32'h0);
    rs_ex = '0; stg_rd = '0; stg_we = 2'b11; #1;
    check("fwd_x0",    32'(fwd_sel), 32'h0);
    check("fwd_any0",  32'(fwd_any), 32'd0);
    clear_inputs();

    // load-use
    ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd7; rs_id = {5'd7, 5'd0}; #1;
    check("lu_stall",  32'(stall_id), 32'd1);
    check("lu_cause",  32'(stall_cause), 32'h1);
    ex_rd = 5'd0; rs_id = {5'd0, 5'd0}; #1;
    check("lu_x0",     32'(stall_id), 32'd0);
    ex_rd = 5'd7; rs_id = {5'd7, 5'd0}; ex_is_load = 1'b0; #1;
    check("lu_noload", 32'(stall_id), 32'd0);
    clear_inputs();

    // starts that must not enter BUSY
    ex_mc_start = 1'b1; ex_we = 1'b1; ex_rd = 5'd0; tick();
    check("start_rd0", 32'(mc_busy), 32'd0);
    ex_we = 1'b0; ex_rd = 5'd9; tick();
    check("start_nowe", 32'(mc_busy), 32'd0);
    check("start_noerr", 32'(mc_err), 32'd0);
    clear_inputs();

    // multicycle sequence with mc_done
    ex_mc_start = 1'b1; ex_we = 1'b1; ex_rd = 5'd9; #1;
    check("mc_pre_busy", 32'(mc_busy), 32'd0);
    tick();
    ex_mc_start = 1'b0; ex_we = 1'b0; ex_rd = '0;
    check("mc_busy", 32'(mc_busy), 32'd1);
    rs_id = {5'd0, 5'd9}; #1;
    check("mc_dep_cause", 32'(stall_cause), 32'h2);
    rs_id = {5'd3, 5'd4}; id_is_mc = 1'b1; #1;
    check("mc_struct_cause", 32'(stall_cause), 32'h3);
    id_is_mc = 1'b0; rs_id = {5'd4, 5'd9}; ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd4; #1;
    check("prio_cause", 32'(stall_cause), 32'h1);
    ex_is_load = 1'b0; ex_we = 1'b0; ex_rd = '0; rs_id = {5'd0, 5'd9};
    for (int i = 0; i < 18; i++) tick();
    mc_done = 1'b1; #1;
    check("done_stall", 32'(stall_id), 32'd1);
    check("done_cause", 32'(stall_cause), 32'h2);
    tick();
    mc_done = 1'b0; #1;
    check("rel_stall", 32'(stall_id), 32'd0);
    check("rel_busy",  32'(mc_busy), 32'd0);
    check("rel_err",   32'(mc_err), 32'd0);
    clear_inputs();

    // illegal start while BUSY
    start_mc(5'd9);
    ex_mc_start = 1'b1; ex_we = 1'b1; ex_rd = 5'd12; tick();
    clear_inputs();
    check("ill_busy", 32'(mc_busy), 32'd1);
    check("ill_err",  32'(mc_err), 32'd1);
    rs_id = {5'd0, 5'd9}; #1;
    check("ill_rd_kept", 32'(stall_cause), 32'h2);
    rs_id = {5'd0, 5'd12}; #1;
    check("ill_rd_new", 32'(stall_id), 32'd0);
    mc_done = 1'b1; tick(); clear_inputs();
    check("ill_idle", 32'(mc_busy), 32'd0);
    check("ill_sticky", 32'(mc_err), 32'd1);
    rst_n = 1'b0; #1;
    check("ill_rst_clr", 32'(mc_err), 32'd0);
    rst_n = 1'b1; tick();

    // timeout: BUSY for exactly MC_TIMEOUT cycles
    start_mc(5'd9);
    for (int i = 0; i < MC_TIMEOUT - 1; i++) tick();
    check("to_still_busy", 32'(mc_busy), 32'd1);
    check("to_no_err", 32'(mc_err), 32'd0);
    tick();
    check("to_idle", 32'(mc_busy), 32'd0);
    check("to_err",  32'(mc_err), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    check("to_sticky", 32'(mc_err), 32'd1);
    do_reset();

    // simultaneous mc_done and start in BUSY
    start_mc(5'd9);
    mc_done = 1'b1; ex_mc_start = 1'b1; ex_we = 1'b1; ex_rd = 5'd10; tick();
    clear_inputs();
    check("sim_idle", 32'(mc_busy), 32'd0);
    check("sim_err",  32'(mc_err), 32'd1);
    do_reset();

    // asynchronous reset mid-BUSY
    start_mc(5'd9);
    rs_id = {5'd0, 5'd9}; #1;
    check("ar_pre_stall", 32'(stall_id), 32'd1);
    rst_n = 1'b0; #1;
    check("ar_busy",  32'(mc_busy), 32'd0);
    check("ar_stall", 32'(stall_id), 32'd0);
    check("ar_state", 32'(mc_state), 32'(IDLE));

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the in-order RISC-V pipeline, placed between the ID and EX stages.
- Selects per-operand bypass sources from any number of downstream stages, youngest-first.
- Detects load-use hazards.
- Tracks one outstanding multicycle operation (mul/div) with a scoreboard FSM and timeout counter, and stalls ID while a dependence or structural conflict exists.

## Interface
Parameters:
- REG_W, 5, register index width
- NUM_SRC, 2, source operands per instruction
- NUM_STG, 2, forwarding stages; index 0 = EX/MEM (youngest), NUM_STG-1 = oldest
- MC_TIMEOUT, 64, max cycles a multicycle op may stay outstanding
- SEL_W, $clog2(NUM_STG+1), bypass select width (derived)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- rs_ex  in  NUM_SRC×REG_W  sources of the instruction in ID/EX
- stg_rd  in  NUM_STG×REG_W  destination per stage
- stg_we  in  NUM_STG  RegWrite per stage
- rs_id  in  NUM_SRC×REG_W  sources of the instruction in IF/ID
- id_is_mc  in  1  IF/ID instruction is multicycle
- ex_rd, ex_we, ex_is_load  in  REG_W,1,1  ID/EX destination info
- ex_mc_start  in  1  multicycle op leaves EX this cycle
- mc_done  in  1  multicycle result written to register file this cycle
- fwd_sel  out  NUM_SRC×SEL_W  0 = register file, k = stage k-1
- fwd_any  out  1  OR of all nonzero fwd_sel
- stall_id  out  1  hold PC/IF-ID, insert bubble into ID/EX
- stall_cause  out  2  00 none, 01 load-use, 10 mc-dependence, 11 mc-structural
- mc_busy  out  1  FSM in BUSY
- mc_err  out  1  sticky: timeout or illegal start

## Operation
- Forwarding (combinational):
  - For each source s, fwd_sel[s] = k+1 for the lowest k with stg_we[k] and stg_rd[k]==rs_ex[s] and stg_rd[k]!=0; otherwise 0.
  - x0 is never forwarded.
- Load-use: ex_we and ex_is_load and ex_rd!=0 and ex_rd matches any rs_id → stall_id=1, cause 01.
- Scoreboard FSM, states IDLE and BUSY:
  - IDLE→BUSY on ex_mc_start with ex_we and ex_rd!=0. Latch mc_rd=ex_rd and clear the counter.
  - ex_mc_start with rd==0 or !ex_we does not enter BUSY.
  - BUSY→IDLE on mc_done.
  - BUSY→IDLE when the counter reaches MC_TIMEOUT-1 without mc_done; this sets mc_err.
  - ex_mc_start while BUSY is ignored (state and mc_rd unchanged) and sets mc_err.
- Stalls while BUSY:
  - mc-dependence: any rs_id (nonzero) == mc_rd → stall_id=1, cause 10.
  - mc-structural: id_is_mc → stall_id=1, cause 11.
- Cause priority: load-use > mc-dependence > mc-structural.
- Counter: $clog2(MC_TIMEOUT) bits, increments each BUSY cycle, saturates, and is cleared on entry to BUSY.

## Timing
- Forwarding, stall_id and stall_cause are purely combinational from inputs and state, with zero latency.
- The FSM updates on the rising clk edge.
- In the mc_done cycle, stall stays asserted. Release occurs the following cycle, since the register file is read in the next cycle.
- Simultaneous mc_done and ex_mc_start in BUSY: the FSM returns to IDLE, the start is treated as illegal, and mc_err is set.
- Reset values: state IDLE, mc_rd 0, counter 0, mc_err 0, mc_busy 0.
- With all data inputs at 0 during reset: stall_id 0, stall_cause 00, fwd_sel 0.
- Reset asserted mid-BUSY forces IDLE immediately (asynchronous) and drops stall_id.

## Structure
- Package hazard_pkg holds:
  - stall_cause_e enum
  - mc_state_e {IDLE, BUSY}
  - REG_W default
- Sub-module fwd_select: one instance per source, generated NUM_SRC times. It implements the priority match over NUM_STG stages.
- The FSM, counter, and stall logic live in the top module.

## Test plan
- rs_ex[0]=5, stg_rd={5,5}, stg_we={1,1} → fwd_sel[0]=1. Same with stg_we[0]=0 → fwd_sel[0]=2. rs_ex=0 with matching rd 0 → fwd_sel=0, fwd_any=0.
- ex_is_load=1, ex_we=1, ex_rd=7, rs_id[1]=7 → stall_id=1, cause 01. Same with ex_rd=0 → no stall.
- Multicycle sequence:
  - ex_mc_start with ex_rd=9 → mc_busy=1 next cycle.
  - rs_id[0]=9 → stall cause 10.
  - Pulse mc_done at cycle 20 → stall still high that cycle, low the next, mc_err=0.
- While BUSY, id_is_mc=1 with unrelated sources → cause 11.
- Load-use and mc-dependence together → cause 01.
- No mc_done for MC_TIMEOUT cycles → mc_busy drops after 64 BUSY cycles and mc_err=1, sticky until rst_n low.
- ex_mc_start while BUSY → mc_rd unchanged, mc_err=1.
- Assert rst_n=0 mid-BUSY → mc_busy and stall_id low without a clock edge.
